// File: rtl/regfile_dump_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_dump_ctrl
//
// Hardware sequencer for the processor/regfile harness. The block:
//   1. holds the CPU (and its regfile) in reset until a start request,
//   2. releases the CPU for exactly `len` clock edges,
//   3. freezes architectural writes, takes over regfile read port A and
//      streams r0..r(NUM_REGS-1) out on a valid/ready channel,
//   4. parks in DONE with the CPU held in reset until the next start.
//
// It sits between processor, regfile and RAM in the top-level wrapper and
// owns the sharing of read port A and of the regfile/dmem write enables.
//
// Optional build macro: REGDUMP_CHECK_EN
//   When defined, each dumped beat is compared against exp_data. err_count
//   counts differing beats and mismatch pulses for one cycle (registered)
//   after each differing beat. When undefined those ports and that logic
//   are absent; all other behaviour is identical.
//
// Ports:
//   clock        in   system clock, all state on rising edge
//   reset        in   synchronous active-high reset, returns to IDLE
//   start        in   single-cycle run request (IDLE / DONE only)
//   num_cycles   in   run length, sampled on accepted start (0 -> default)
//   cpu_rs1      in   processor's read-port-A address
//   cpu_rwe      in   processor's regfile write enable
//   cpu_mwe      in   processor's data-memory write enable
//   rf_data_a    in   regfile read-port-A data
//   rf_rs1       out  regfile read-port-A address (muxed)
//   rf_rwe       out  regfile write enable (masked in test mode)
//   rf_mwe       out  data-memory write enable (masked in test mode)
//   cpu_reset    out  reset to processor and regfile
//   busy         out  high in RUN or DUMP
//   done         out  high in DONE
//   cycle_count  out  edges elapsed in current/last run (saturating)
//   out_valid    out  dump beat valid
//   out_ready    in   consumer accepts beat
//   out_reg      out  register index of current beat
//   out_data     out  register value of current beat
//   exp_data     in   expected beat value          (REGDUMP_CHECK_EN only)
//   err_count    out  number of differing beats    (REGDUMP_CHECK_EN only)
//   mismatch     out  one-cycle pulse per diff     (REGDUMP_CHECK_EN only)
// -----------------------------------------------------------------------------
module regfile_dump_ctrl #(
    parameter int NUM_REGS       = 32,
    parameter int CYCLE_W        = 8,
    parameter int DEFAULT_CYCLES = 255,
    parameter int DATA_W         = 32,
    localparam int IDX_W         = $clog2(NUM_REGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [CYCLE_W-1:0]  num_cycles,
    input  logic [IDX_W-1:0]    cpu_rs1,
    input  logic                cpu_rwe,
    input  logic                cpu_mwe,
    input  logic [DATA_W-1:0]   rf_data_a,
    output logic [IDX_W-1:0]    rf_rs1,
    output logic                rf_rwe,
    output logic                rf_mwe,
    output logic                cpu_reset,
    output logic                busy,
    output logic                done,
    output logic [CYCLE_W-1:0]  cycle_count,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    out_reg,
    output logic [DATA_W-1:0]   out_data
`ifdef REGDUMP_CHECK_EN
    ,
    input  logic [DATA_W-1:0]   exp_data,
    output logic [5:0]          err_count,
    output logic                mismatch
`endif
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DUMP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CYCLE_W-1:0] DEF_LEN  = CYCLE_W'(DEFAULT_CYCLES);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REGS - 1);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Saturating increment for the run-length counter. The counter can never
    // legitimately exceed len (<= 2^CYCLE_W-1), so saturation only guards
    // against wrap should the compare ever be missed.
    function automatic logic [CYCLE_W-1:0] sat_inc_cyc(input logic [CYCLE_W-1:0] v);
        logic [CYCLE_W-1:0] r;
        if (v == {CYCLE_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

    // A requested length of zero selects the default run length.
    function automatic logic [CYCLE_W-1:0] select_len(input logic [CYCLE_W-1:0] n);
        logic [CYCLE_W-1:0] r;
        if (n == '0) begin
            r = DEF_LEN;
        end else begin
            r = n;
        end
        return r;
    endfunction

`ifdef REGDUMP_CHECK_EN
    // Error counter saturates rather than wrapping back to a clean-looking 0.
    function automatic logic [5:0] sat_inc_err(input logic [5:0] v);
        logic [5:0] r;
        if (v == 6'h3f) begin
            r = v;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]         state;
    logic [CYCLE_W-1:0] run_len;
    logic [CYCLE_W-1:0] cyc_cnt;
    logic [IDX_W-1:0]   dump_idx;

    // -------------------------------------------------------------------------
    // Decoded control
    // -------------------------------------------------------------------------
    logic test_mode;
    logic start_acc;
    logic run_last;
    logic beat_xfer;
    logic beat_last;

    // Test mode covers DUMP and DONE: the regfile read port belongs to the
    // dump sequencer and all architectural writes are blocked.
    assign test_mode = (state == ST_DUMP) || (state == ST_DONE);

    // start is only honoured from the parked states; RUN and DUMP ignore it.
    assign start_acc = start && ((state == ST_IDLE) || (state == ST_DONE));

    // The edge on which the count goes from len-1 to len is the last RUN edge,
    // giving exactly len edges with cpu_reset low.
    assign run_last  = (state == ST_RUN) && (cyc_cnt == run_len - 1'b1);

    assign beat_xfer = (state == ST_DUMP) && out_ready;
    assign beat_last = beat_xfer && (dump_idx == LAST_IDX);

    // -------------------------------------------------------------------------
    // Sequencer state machine
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            run_len  <= '0;
            cyc_cnt  <= '0;
            dump_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_acc) begin
                        state   <= ST_RUN;
                        run_len <= select_len(num_cycles);
                        cyc_cnt <= '0;
                    end
                end

                ST_RUN: begin
                    cyc_cnt <= sat_inc_cyc(cyc_cnt);
                    if (run_last) begin
                        state <= ST_DUMP;
                    end
                end

                ST_DUMP: begin
                    if (beat_last) begin
                        state    <= ST_DONE;
                        dump_idx <= '0;
                    end else if (beat_xfer) begin
                        dump_idx <= dump_idx + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (start_acc) begin
                        state    <= ST_RUN;
                        run_len  <= select_len(num_cycles);
                        cyc_cnt  <= '0;
                        dump_idx <= '0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Port sharing: combinational, no added latency on the CPU path
    // -------------------------------------------------------------------------
    assign rf_rs1 = test_mode ? dump_idx : cpu_rs1;
    assign rf_rwe = cpu_rwe & ~test_mode;
    assign rf_mwe = cpu_mwe & ~test_mode;

    // -------------------------------------------------------------------------
    // Status and dump channel
    // -------------------------------------------------------------------------
    // The CPU keeps running (writes masked) during DUMP so that the regfile
    // contents survive; it is only held in reset while parked.
    assign cpu_reset   = (state == ST_IDLE) || (state == ST_DONE);
    assign busy        = (state == ST_RUN)  || (state == ST_DUMP);
    assign done        = (state == ST_DONE);
    assign cycle_count = cyc_cnt;

    // Read data is stable while a beat is stalled because writes are masked
    // and the read address only moves on a transfer.
    assign out_valid = (state == ST_DUMP);
    assign out_reg   = dump_idx;
    assign out_data  = rf_data_a;

`ifdef REGDUMP_CHECK_EN
    // -------------------------------------------------------------------------
    // Optional dump checker
    // -------------------------------------------------------------------------
    logic [5:0] err_cnt;
    logic       mismatch_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_cnt    <= '0;
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= 1'b0;
            if (start_acc) begin
                err_cnt <= '0;
            end else if (beat_xfer && (rf_data_a != exp_data)) begin
                err_cnt    <= sat_inc_err(err_cnt);
                mismatch_q <= 1'b1;
            end
        end
    end

    assign err_count = err_cnt;
    assign mismatch  = mismatch_q;
`endif

endmodule
